sfx_scheduler: RTL
==================

# sfx_scheduler

Multi-channel sound-effect scheduler for the audio subsystem. It shares one audio sample ROM read port between four independently triggered playback channels. On each codec sample request it fetches one sample per active channel, mixes them with saturation and presents the result as the codec's next output sample. Software arms channels over the Avalon slave bus, and an interrupt signals clip completion to the HPS.

## Interface
- `NCH`, 4: number of playback channels; fixed at 4 by the register map.
- `AW`, 15: ROM word-address width.
- `clk`  in  1: audio clock; all logic is in this single domain.
- `reset`  in  1: synchronous, active-high.
- `chipselect`  in  1: Avalon slave select.
- `write`  in  1: Avalon write strobe; a write takes effect when `chipselect && write`.
- `address`  in  4: register index.
- `writedata`  in  16: register data.
- `irq`  out  1: high while any bit of `pending` is set.
- `sample_req`  in  1: one-cycle pulse from the codec requesting the next sample.
- `audio_output`  out  16: signed mixed sample; holds until the next mix completes.
- `rom_addr`  out  AW: registered ROM address.
- `rom_q`  in  16: signed ROM data, valid 2 clocks after `rom_addr` changes.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Per-channel state: `start[k]` (AW), `cur[k]` (AW), `remain[k]` (15), `loop[k]`, `active[k]`, `pending[k]`.
- Register map, write-only:
  - addr `2k` (k = 0..3): `start[k] <= writedata[AW-1:0]`.
  - addr `2k+1`, nonzero length field: `cur[k] <= start[k]`, `remain[k] <= writedata[14:0]`, `loop[k] <= writedata[15]`, `active[k] <= 1`.
  - addr `2k+1`, `writedata[14:0] == 0`: `active[k] <= 0`. No pending bit is set.
  - addr 8: write-1-to-clear `pending[3:0]` using `writedata[3:0]`.
  - addr 9–15: writes are ignored.
- FSM states: IDLE, ISSUE, WAIT1, WAIT2, CAPTURE, OUT.
  - IDLE: on `sample_req`, set `ch <= 0`, `acc <= 0`, go to ISSUE.
  - ISSUE, `active[ch]` set: `rom_addr <= cur[ch]`, go to WAIT1.
  - ISSUE, `active[ch]` clear: if `ch == 3` go to OUT; otherwise `ch++` and stay in ISSUE.
  - WAIT1 goes to WAIT2; WAIT2 goes to CAPTURE.
  - CAPTURE: `acc <= acc + sext(rom_q)`, with `acc` 18 bits signed.
    - Advance: `cur[ch]++`, wrapping modulo 2^AW, and `remain[ch]--`.
    - If `remain[ch]` was 1 and `loop[ch]` is set: `cur <= start`, `remain <= original length`. A shadow `len[k]` register holds the original length.
    - If `remain[ch]` was 1 and `loop[ch]` is clear: `active[ch] <= 0`, `pending[ch] <= 1`.
    - Then, if `ch == 3` go to OUT; otherwise `ch++` and go to ISSUE.
  - OUT: `audio_output <= sat16(acc)`, go to IDLE. `sat16` clamps to the range 0x8000..0x7FFF.
- `sample_req` arriving while not in IDLE is ignored. No queuing; `audio_output` keeps its previous value.
- A register write to channel k that coincides with CAPTURE for channel k: the bus write wins for every field it touches.
- A pending-set and a clear on the same cycle for the same bit: the bit ends up set.
- Bus writes are accepted in every FSM state. A length write to a channel already scanned in the current pass takes effect on the next `sample_req`.

## Timing
- Reset values: `audio_output` = 0, `rom_addr` = 0, `irq` = 0, `busy` = 0. All channel registers are 0 and the FSM is in IDLE.
- A `reset` asserted mid-pass aborts the pass on the next edge. `audio_output` is forced to 0.
- Cost per pass: an active channel takes 4 cycles (ISSUE through CAPTURE); an inactive channel takes 1 cycle.
- Latency, measured from `sample_req` high in cycle 0:
  - All four channels active: OUT in cycle 17, new `audio_output` visible in cycle 18.
  - No channels active: OUT in cycle 5, output 0 visible in cycle 6.
- `irq` follows `pending` with 1 cycle of register delay. It is never pulsed; it stays level until software clears it.
- `busy` rises the cycle after `sample_req` is accepted and falls the cycle after OUT.

## Test plan
- **Reset and idle pass.** Release reset, then pulse `sample_req`. Expect `audio_output` = 0 at cycle 6, `irq` = 0, and `rom_addr` never changes.
- **Single one-shot clip.** Program ch1 with start 0x0100 and length 3, ROM returning addr & 0xFF.
  - Three requests produce outputs 0x0000, 0x0001, 0x0002.
  - After the third, `active[1]` = 0 and `irq` = 1.
  - A write of 0x0002 to addr 8 clears `irq`.
- **Four-channel saturation.** All four channels active with ROM returning 0x7000. Expect output 0x7FFF, visible 18 cycles after the request. Repeat with 0x9000 and expect 0x8000.
- **Looping clip.** Ch0 with start 0x10, length 2 and the loop bit set. Expect the addresses 0x10, 0x11, 0x10, 0x11 across four requests, with `irq` staying 0.
- **Overrun and stop.** Pulse `sample_req` again while `busy` is high; expect it ignored and exactly one output update.
  - Write length 0 to the channel mid-pass; expect no `pending` bit set and the channel skipped on the next pass.
- **Address wrap.** Start 0x7FFF, length 2. Expect the fetch sequence 0x7FFF then 0x0000, and the completion interrupt set.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Four-channel sound-effect scheduler: one shared ROM read port, per-request
// fetch of every active channel, saturating mix into a 16-bit codec sample.
module sfx_scheduler #(
  parameter int NCH = 4,
  parameter int AW  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          chipselect,
  input  logic          write,
  input  logic [3:0]    address,
  input  logic [15:0]   writedata,
  output logic          irq,
  input  logic          sample_req,
  output logic [15:0]   audio_output,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_q,
  output logic          busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT1   = 3'd2;
  localparam logic [2:0] S_WAIT2   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [1:0] LAST_CH   = 2'd3;

  logic [2:0]        state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic signed [17:0] acc_q, acc_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [15:0]       audio_q, audio_d;
  logic [15:0]       sat_val;
  logic              irq_q;

  logic [AW-1:0]     cur_w [NCH];
  logic [NCH-1:0]    active_w;
  logic [NCH-1:0]    pending_w;

  logic wr_en;
  assign wr_en = chipselect && write;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : ch_g
      logic [AW-1:0] start_q, cur_q;
      logic [14:0]   remain_q, len_q;
      logic          loop_q, active_q, pending_q;
      logic          sel_start, sel_len, sel_clr, cap, last;

      assign sel_start = wr_en && (address == 4'(2 * gi));
      assign sel_len   = wr_en && (address == 4'(2 * gi + 1));
      assign sel_clr   = wr_en && (address == 4'd8) && writedata[gi];
      assign cap       = (state_q == S_CAPTURE) && (ch_q == 2'(gi));
      assign last      = (remain_q == 15'd1);

      // Bus length writes are placed after the capture update so they win.
      always_ff @(posedge clk) begin
        if (reset) begin
          start_q   <= '0;
          cur_q     <= '0;
          remain_q  <= '0;
          len_q     <= '0;
          loop_q    <= 1'b0;
          active_q  <= 1'b0;
          pending_q <= 1'b0;
        end else begin
          if (sel_start) start_q <= writedata[AW-1:0];
          if (cap) begin
            if (last && loop_q) begin
              cur_q    <= start_q;
              remain_q <= len_q;
            end else begin
              cur_q    <= cur_q + AW'(1);
              remain_q <= remain_q - 15'd1;
              if (last) active_q <= 1'b0;
            end
          end
          if (sel_len) begin
            if (writedata[14:0] != 15'd0) begin
              cur_q    <= start_q;
              remain_q <= writedata[14:0];
              len_q    <= writedata[14:0];
              loop_q   <= writedata[15];
              active_q <= 1'b1;
            end else begin
              active_q <= 1'b0;
            end
          end
          if (cap && last && !loop_q) pending_q <= 1'b1;
          else if (sel_clr)           pending_q <= 1'b0;
        end
      end

      assign cur_w[gi]     = cur_q;
      assign active_w[gi]  = active_q;
      assign pending_w[gi] = pending_q;
    end
  endgenerate

  always_comb begin
    if (acc_q > 18'sd32767)       sat_val = 16'h7FFF;
    else if (acc_q < -18'sd32768) sat_val = 16'h8000;
    else                          sat_val = acc_q[15:0];
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    rom_addr_d = rom_addr_q;
    audio_d    = audio_q;
    case (state_q)
      S_IDLE: begin
        if (sample_req) begin
          ch_d    = 2'd0;
          acc_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (active_w[ch_q]) begin
          rom_addr_d = cur_w[ch_q];
          state_d    = S_WAIT1;
        end else if (ch_q == LAST_CH) begin
          state_d = S_OUT;
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: state_d = S_CAPTURE;
      S_CAPTURE: begin
        acc_d = acc_q + $signed({{2{rom_q[15]}}, rom_q});
        if (ch_q == LAST_CH) begin
          state_d = S_OUT;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_ISSUE;
        end
      end
      S_OUT: begin
        audio_d = sat_val;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= 2'd0;
      acc_q      <= '0;
      rom_addr_q <= '0;
      audio_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      audio_q    <= audio_d;
      irq_q      <= |pending_w;
    end
  end

  assign irq          = irq_q;
  assign busy         = (state_q != S_IDLE);
  assign rom_addr     = rom_addr_q;
  assign audio_output = audio_q;

endmodule
